// File: rtl/divmod_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default width
// and the divide-by-zero result convention.
package divmod_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Division by zero reports a quotient made entirely of this bit (all ones).
  localparam logic DIV0_Q_BIT = 1'b1;

endpackage

// File: rtl/divmod_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference only when it did not borrow.
module divmod_step
  import divmod_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] shifted_lo;

  // The partial remainder is WIDTH+1 bits wide, so diff's MSB is the borrow.
  assign diff       = {rem_i, dvd_bit_i} - {1'b0, div_i};
  assign shifted_lo = {rem_i[WIDTH-2:0], dvd_bit_i};
  assign q_bit_o    = ~diff[WIDTH];
  assign rem_o      = q_bit_o ? diff[WIDTH-1:0] : shifted_lo;

endmodule

// File: rtl/seq_divmod.sv
// Multi-cycle unsigned divider returning quotient and remainder, one quotient
// bit per clock, with a start/done handshake.
module seq_divmod
  import divmod_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             div0_o,
  output state_e           state_o
);

  // Handshake: start_i is accepted on any edge where busy_o is low (including
  // the done_o cycle); a_i/b_i are captured only on that edge. done_o pulses
  // for one cycle and q_o/r_o/div0_o hold until the next done_o.
  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  divmod_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dq_q[WIDTH-1]),
    .div_i     (b_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          b_d     = b_i;
          dq_d    = a_i;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (b_i == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        // dq_q shifts dividend bits out of the top and quotient bits in at the bottom.
        rem_d = step_rem;
        dq_d  = {dq_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (b_q == '0) begin
          q_d    = {WIDTH{DIV0_Q_BIT}};
          r_d    = dq_q;
          div0_d = 1'b1;
        end else begin
          q_d    = dq_q;
          r_d    = rem_q;
          div0_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = done_q;
  assign q_o     = q_q;
  assign r_o     = r_q;
  assign div0_o  = div0_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_divmod.sv
// Directed bench for seq_divmod at WIDTH=4 and WIDTH=8: latency, results,
// divide-by-zero, back-to-back throughput and asynchronous reset mid-run.
module tb_seq_divmod;
  import divmod_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start4, start8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy4, done4, div04;
  logic [3:0] q4, r4;
  logic       busy8, done8, div08;
  logic [7:0] q8, r8;
  state_e     state4, state8;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  seq_divmod #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .a_i(a4), .b_i(b4),
    .busy_o(busy4), .done_o(done4), .q_o(q4), .r_o(r4), .div0_o(div04),
    .state_o(state4)
  );

  seq_divmod #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .q_o(q8), .r_o(r8), .div0_o(div08),
    .state_o(state8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one operation on the chosen DUT and check its result and timing.
  task automatic run_op(input bit wide, input int a, input int b,
                        input int eq, input int er, input int ed, input int elat);
    int lat;
    logic d;
    @(negedge clk);
    if (wide) begin start8 = 1'b1; a8 = 8'(a); b8 = 8'(b); end
    else      begin start4 = 1'b1; a4 = 4'(a); b4 = 4'(b); end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    check("busy_after_start", wide ? busy8 : busy4, 1);
    lat = 0;
    d = wide ? done8 : done4;
    while (!d && lat < 30) begin
      @(negedge clk);
      lat++;
      d = wide ? done8 : done4;
    end
    check("latency", 32'(lat), 32'(elat));
    check("quotient", wide ? 32'(q8) : 32'(q4), 32'(eq));
    check("remainder", wide ? 32'(r8) : 32'(r4), 32'(er));
    check("div0", wide ? 32'(div08) : 32'(div04), 32'(ed));
    check("busy_on_done", wide ? busy8 : busy4, 0);
    @(negedge clk);
    check("done_width", wide ? done8 : done4, 0);
  endtask

  initial begin
    int seen;
    int cyc;
    int last;
    int w;
    logic [7:0] e;
    int ta[4];
    int tb_b[4];

    rst_n  = 1'b0;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_q", 32'(q4), 0);
    check("rst_r", 32'(r4), 0);
    check("rst_div0", div04, 0);
    check("rst_state", 32'(state4), 32'(S_IDLE));
    rst_n = 1'b1;

    // divide by zero, then a normal op clearing div0
    run_op(0, 7, 0, 15, 7, 1, 1);
    run_op(0, 3, 5, 0, 3, 0, 5);
    // 13/4
    run_op(0, 13, 4, 3, 1, 0, 5);

    // asynchronous reset two steps into 15/2
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd2;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_q", 32'(q4), 0);
    check("arst_r", 32'(r4), 0);
    check("arst_state", 32'(state4), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4) seen++;
    end
    check("arst_no_done", 32'(seen), 0);
    run_op(0, 15, 2, 7, 1, 0, 5);

    // every dividend with every non-zero divisor
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        run_op(0, a, b, a / b, a % b, 0, 5);

    // start held high, operands scrambled while busy
    ta   = '{9, 14, 15, 6};
    tb_b = '{2, 3, 15, 7};
    exp_q.push_back({4'd4, 4'd1});
    exp_q.push_back({4'd4, 4'd2});
    exp_q.push_back({4'd1, 4'd0});
    exp_q.push_back({4'd0, 4'd6});
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd2;
    cyc = 0;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        cyc++;
        w++;
        if (!done4) begin
          a4 = 4'($urandom_range(0, 15));
          b4 = 4'($urandom_range(0, 15));
        end
      end while (!done4 && w < 30);
      check("b2b_done_seen", done4, 1);
      e = exp_q.pop_front();
      check("b2b_q", 32'(q4), 32'(e[7:4]));
      check("b2b_r", 32'(r4), 32'(e[3:0]));
      if (k > 0) check("b2b_period", 32'(cyc - last), 6);
      last = cyc;
      if (k < 3) begin
        a4 = 4'(ta[k+1]);
        b4 = 4'(tb_b[k+1]);
      end else begin
        start4 = 1'b0;
      end
    end
    @(negedge clk);

    // eight-bit instance
    run_op(1, 255, 1, 255, 0, 0, 9);
    run_op(1, 200, 201, 0, 200, 0, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
